// File: rtl/div_iter.sv
// div_iter: radix-2 restoring 32-bit DIV/DIVU; optional early-out under DIV_EARLY_OUT_EN.
// Latency: ready at N+33 after acceptance (N+1 for divide-by-zero or early-out).
// Backpressure: start is held by the hazard unit until ready; dropping start or annul aborts.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   rem;
  logic               q_neg, r_neg;
  logic [5:0]         cnt;
  logic [2*WIDTH-1:0] result_q;
  logic [2*WIDTH-1:0] result_new;

  logic               accept;
  logic               div_zero;
  logic               early_out;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH+1:0]   trial;
  logic               borrow;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept   = (state == IDLE) && start && !annul;
  assign div_zero = (opdata2 == '0);
  assign abs1     = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign abs2     = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = !div_zero && (abs1 < abs2);
`else
  assign early_out = 1'b0;
`endif

  // Partial remainder stays below the divisor, so a clean subtract never sets bit WIDTH.
  assign trial  = {1'b0, rem, dvd[WIDTH-1]} - {2'b00, dvs};
  assign borrow = trial[WIDTH+1] | trial[WIDTH];

  assign quo_fix    = q_neg ? -dvd : dvd;
  assign rem_fix    = r_neg ? -rem : rem;
  assign result_new = {rem_fix, quo_fix};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (div_zero || early_out) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (annul || !start) begin
          state_nxt = IDLE;
        end else if (cnt == 6'(WIDTH-1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        ready     = !annul;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            dvs <= abs2;
            if (div_zero || early_out) begin
              // Shortcut results are returned raw, without sign fix-up.
              dvd   <= div_zero ? '1 : '0;
              rem   <= opdata1;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
            end else begin
              dvd   <= abs1;
              rem   <= '0;
              q_neg <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
              r_neg <= signed_div & opdata1[WIDTH-1];
            end
          end
        end
        BUSY: begin
          if (!borrow) begin
            rem <= trial[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            rem <= {rem[WIDTH-2:0], dvd[WIDTH-1]};
            dvd <= {dvd[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 6'd1;
        end
        DONE: begin
          if (!annul) begin
            result_q <= result_new;
          end
        end
        default: ;
      endcase
    end
  end

  // The fixed-up result is visible in the ready cycle and held afterwards.
  assign result = ready ? result_new : result_q;

endmodule

// File: doc/div_iter.md
# div_iter

Multi-cycle iterative 32-bit integer divider for the EX stage, serving DIV and DIVU. It is the responder on the `div_start`/`div_ready` handshake driven by the hazard unit. While the hazard unit holds start high, the front of the pipeline stalls. The divider runs a radix-2 restoring division and pulses `ready` for exactly one cycle with `{remainder, quotient}`. The hazard unit then drops start and releases the pipeline on that same cycle.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Result is 2*WIDTH. Only 32 is verified.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request from the hazard unit. Held high until `ready` is seen.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1`  in  32  dividend, sampled only on acceptance.
- `opdata2`  in  32  divisor, sampled only on acceptance.
- `annul`  in  1  exception flush; aborts any operation in progress.
- `ready`  out  1  one-cycle pulse: result valid.
- `result`  out  64  `{hi = remainder, lo = quotient}`.

## Operation
- States: IDLE, BUSY, DONE. Counter `cnt` is 6 bits.
- Reset values: state IDLE, `ready` 0, `result` 0, `cnt` 0.

IDLE
- Start is accepted when `start` = 1 and `annul` = 0.
- On acceptance, latch the absolute values of the operands (absolute values only when `signed_div` = 1; otherwise raw values).
- On acceptance, latch the quotient sign (the XOR of the operand MSBs) and the remainder sign (the dividend MSB).
- On acceptance, clear the partial remainder, set `cnt` = 0, and go to BUSY.
- Divisor equal to 0: skip BUSY and go straight to DONE.
  - Quotient is 32'hFFFFFFFF.
  - Remainder is the raw `opdata1`.
  - Applies to both signed and unsigned division.

BUSY
- Each cycle:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor with a 33-bit subtract.
  - If there is no borrow, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - `cnt` increments.
- After the 32nd iteration (`cnt` = 31), go to DONE.

DONE
- Apply signs: negate the quotient if its sign is set; negate the remainder if the dividend was negative.
- Register `result`, assert `ready` = 1, and return to IDLE next cycle.
- 32'h80000000 / 32'hFFFFFFFF (signed) wraps: quotient 32'h80000000, remainder 0.

Abort
- `annul` = 1, or `start` = 0, while in BUSY: return to IDLE next edge.
- No `ready`; `result` is unchanged.
- `annul` in DONE: `ready` is still 0 that cycle, and `result` is not updated.

Hold behaviour
- `result` holds its value between operations.
- `ready` = 1 only in DONE.

## Timing
- Cycle N: IDLE, `start` = 1 → operands latched at the end of N.
- Cycles N+1 … N+32: BUSY.
- Cycle N+33: DONE, `ready` = 1, `result` valid (registered).
- Cycle N+34: IDLE. A new `start` asserted in N+34 is accepted immediately.
- Divide by zero: `ready` is asserted in cycle N+1.
- `start` in DONE is ignored. Under the handshake it is already low, because `start` = DIV and !`ready`.
- `resetn` low at any cycle immediately forces IDLE, `ready` 0 and `result` 0, with no clock needed.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - In IDLE, if |dividend| < |divisor| with a nonzero divisor, go straight to DONE.
  - Quotient is 0; remainder is the raw `opdata1`.
  - `ready` is asserted in N+1.
- `DIV_EARLY_OUT_EN` undefined:
  - Every nonzero-divisor operation takes exactly 33 cycles to `ready`.
  - The comparator is not synthesized.

## Test plan
- DIVU 100 / 7, `start` held: `ready` exactly at N+33 for one cycle; lo = 14, hi = 2; `start` drops → next cycle IDLE.
- DIV 32'hFFFFFFF9 (−7) / 2: lo = 32'hFFFFFFFD (−3), hi = 32'hFFFFFFFF (−1). DIV 7 / −2: lo = −3, hi = 1.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo = 32'h80000000, hi = 0. DIVU 5 / 0: `ready` at N+1, lo = 32'hFFFFFFFF, hi = 5.
- Start DIVU 9 / 3, assert `annul` at BUSY cycle 10: no `ready` ever, `result` unchanged. Restart 9 / 3: `ready` at N+33 with lo = 3, hi = 0.
- Pull `resetn` low at BUSY cycle 20: `ready` = 0 and `result` = 0 immediately. After release, DIVU 1000 / 10 gives lo = 100, hi = 0.
- With `DIV_EARLY_OUT_EN`: DIVU 3 / 8 gives `ready` at N+1 with lo = 0, hi = 3. Without it, `ready` comes at N+33 with the same values.
